captura_jogada: RTL and testbench
=================================

Name: captura_jogada

Overview:
- Upstream input stage of the memory game datapath; sits between the board switches (chaves) and the game circuit's jogada register/comparator.
- Synchronises and debounces the 4-bit chaves, and registers one stable nonzero pattern per press.
- Emits a one-cycle jogada_feita pulse per accepted press, and re-arms only after the switches have returned stably to zero.

Parameters:
- DEBOUNCE_CICLOS, default 4: consecutive identical synchronised samples required to accept a press or a release; legal range >= 1.
- CW, default 3: width of the stability counter; must satisfy 2^CW > DEBOUNCE_CICLOS.

Ports:
- clock  in  1  system clock, 50 MHz; all logic on its rising edge
- reset  in  1  synchronous, active-high; clears all state
- habilita  in  1  from the control unit; a press is captured only while high
- chaves  in  4  raw switch inputs, asynchronous
- jogada  out  4  last accepted pattern; held until the next accept or reset
- jogada_feita  out  1  one-cycle pulse on accept
- multipla  out  1  high together with jogada_feita when the accepted pattern has more than one bit set
- db_tem_jogada  out  1  high from accept until release is confirmed
- db_estado  out  4  state code, for hex display

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values: jogada=0000, jogada_feita=0, multipla=0, db_tem_jogada=0, db_estado=0000. Synchroniser flops, sample register and counter are all cleared.
- Reset mid-operation: returns to OCIOSO on that edge, whatever the state. No pulse is emitted.
- Synchroniser: two flops. The FSM sees s = chaves delayed by 2 clocks.
- Counter: cnt clears whenever s differs from the previous sample. It increments while s equals the previous sample, and saturates at DEBOUNCE_CICLOS.
- State OCIOSO (0000): cnt held at 0. If s!=0 and habilita=1, latch s as candidate, set cnt=1, go to ESTABILIZANDO.
- State ESTABILIZANDO (0001), on each edge:
  - if s==0, or habilita==0, go to OCIOSO (glitch rejected);
  - else if s!=candidate, reload candidate=s and cnt=1;
  - else cnt++; when cnt reaches DEBOUNCE_CICLOS, accept.
- Accept: registered outputs update on the same edge. jogada<=candidate; jogada_feita<=1 for exactly one cycle; multipla<=(popcount(candidate)>1) for that same cycle; state goes to VALIDO.
- State VALIDO (0010), db_tem_jogada=1: changes to other nonzero patterns are ignored. When s==0, set cnt=1 and go to LIBERANDO.
- State LIBERANDO (0011), db_tem_jogada=1:
  - s!=0: return to VALIDO; no new pulse.
  - s==0 for DEBOUNCE_CICLOS consecutive samples: go to OCIOSO and clear db_tem_jogada.
- habilita is ignored in VALIDO and LIBERANDO, so a release always completes.
- Latency: a clean press applied just before rising edge E0 gives jogada_feita high in the cycle after edge E(1+DEBOUNCE_CICLOS). With the default this is 6 cycles after the change. Minimum accepted press width = DEBOUNCE_CICLOS cycles.
- Guarantees: at most one jogada_feita per press-release cycle. Never two pulses on consecutive cycles.
- Unused state codes go to OCIOSO.

Test Plan:
- Reset, then habilita=1, chaves=0001 for 10 cycles, then 0000 -> jogada_feita pulses exactly once, 6 cycles after the change; jogada=0001; multipla=0; db_tem_jogada=1 until 4 cycles after the synchronised release.
- Glitch: chaves=0100 for 3 cycles, then 0000 -> no jogada_feita; jogada keeps its previous value; state returns to 0000.
- Minimum-width wrong play: chaves=0001 for 5 cycles -> one pulse, jogada=0001. Next press 1000 for 10 cycles -> one more pulse, jogada=1000.
- Multiple keys: chaves=0110 for 10 cycles -> jogada=0110; multipla=1 in the same cycle as jogada_feita; 0 otherwise.
- Bounce on release: after accept of 0010, apply 0000 for 2 cycles, 0010 for 2 cycles, then 0000 -> no second pulse; db_tem_jogada falls only after 4 stable zero samples.
- habilita=0 during press -> no capture. Reset asserted in VALIDO -> all outputs 0000/0 the next cycle. Keys still held after reset -> captured again once habilita=1 and stable for 4 samples.

Source files
------------

// File: rtl/captura_jogada_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : captura_jogada_if
//  Description : Switch-side and game-side signals of the play capture stage.
//                The master drives habilita/chaves and observes the capture
//                results; the slave (capture stage) does the opposite.
//  Revision    : 1.0 - initial release
// ============================================================================
interface captura_jogada_if;
  logic       habilita;
  logic [3:0] chaves;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       multipla;
  logic       db_tem_jogada;
  logic [3:0] db_estado;

  modport master (
    output habilita,
    output chaves,
    input  jogada,
    input  jogada_feita,
    input  multipla,
    input  db_tem_jogada,
    input  db_estado
  );

  modport slave (
    input  habilita,
    input  chaves,
    output jogada,
    output jogada_feita,
    output multipla,
    output db_tem_jogada,
    output db_estado
  );
endinterface
`default_nettype wire

// File: rtl/captura_jogada.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : captura_jogada
//  Description : Synchronises and debounces the 4-bit switch bank, registers
//                one stable nonzero pattern per press and emits a single
//                jogada_feita pulse; re-arms only after a stable release.
//  Revision    : 1.0 - initial release
// ============================================================================
module captura_jogada #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int CW              = 3
) (
  input  logic            clock,
  input  logic            reset,
  captura_jogada_if.slave bus
);

  // State codes double as the debug display value.
  localparam logic [3:0] c_ocioso        = 4'b0000;
  localparam logic [3:0] c_estabilizando = 4'b0001;
  localparam logic [3:0] c_valido        = 4'b0010;
  localparam logic [3:0] c_liberando     = 4'b0011;

  localparam logic [CW-1:0] c_cnt_zero = '0;
  localparam logic [CW-1:0] c_cnt_um   = CW'(1);
  localparam logic [CW-1:0] c_cnt_alvo = CW'(DEBOUNCE_CICLOS);

  // Two-flop synchroniser for the asynchronous switches.
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;

  logic [3:0]    r_estado;
  logic [3:0]    w_estado_prox;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_prox;
  logic [CW-1:0] w_cnt_inc;
  logic [3:0]    r_candidato;
  logic [3:0]    w_cand_prox;
  logic          w_aceita;
  logic          w_multipla;

  logic [3:0]    r_jogada;
  logic          r_jogada_feita;
  logic          r_multipla;
  logic          w_tem_jogada;
  logic [3:0]    w_db_estado;

  logic [3:0]    w_s;

  assign w_s = r_sync2;

  // Stability counter advances by one and saturates at the debounce target.
  assign w_cnt_inc = (r_cnt >= c_cnt_alvo) ? r_cnt : r_cnt + c_cnt_um;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multipla = ((w_cand_prox & (w_cand_prox - 4'd1)) != 4'd0);

  // State register; reset always lands in idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= c_ocioso;
    end else begin
      r_estado <= w_estado_prox;
    end
  end

  // Next-state, counter/candidate update and accept decision.
  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt;
    w_cand_prox   = r_candidato;
    w_aceita      = 1'b0;
    case (r_estado)
      c_ocioso: begin
        w_cnt_prox = c_cnt_zero;
        if ((w_s != 4'b0000) && bus.habilita) begin
          w_cand_prox = w_s;
          w_cnt_prox  = c_cnt_um;
          // A one-sample debounce accepts on the very first sample.
          if (c_cnt_um >= c_cnt_alvo) begin
            w_aceita      = 1'b1;
            w_estado_prox = c_valido;
          end else begin
            w_estado_prox = c_estabilizando;
          end
        end
      end
      c_estabilizando: begin
        if ((w_s == 4'b0000) || !bus.habilita) begin
          w_cnt_prox    = c_cnt_zero;
          w_estado_prox = c_ocioso;
        end else if (w_s != r_candidato) begin
          w_cand_prox = w_s;
          w_cnt_prox  = c_cnt_um;
        end else begin
          w_cnt_prox = w_cnt_inc;
          if (w_cnt_inc >= c_cnt_alvo) begin
            w_aceita      = 1'b1;
            w_estado_prox = c_valido;
          end
        end
      end
      c_valido: begin
        // Other nonzero patterns are ignored until the keys are released.
        if (w_s == 4'b0000) begin
          if (c_cnt_um >= c_cnt_alvo) begin
            w_cnt_prox    = c_cnt_zero;
            w_estado_prox = c_ocioso;
          end else begin
            w_cnt_prox    = c_cnt_um;
            w_estado_prox = c_liberando;
          end
        end
      end
      c_liberando: begin
        if (w_s != 4'b0000) begin
          // Release bounce: back to holding, no new pulse.
          w_cnt_prox    = c_cnt_zero;
          w_estado_prox = c_valido;
        end else begin
          w_cnt_prox = w_cnt_inc;
          if (w_cnt_inc >= c_cnt_alvo) begin
            w_cnt_prox    = c_cnt_zero;
            w_estado_prox = c_ocioso;
          end
        end
      end
      default: begin
        w_cnt_prox    = c_cnt_zero;
        w_estado_prox = c_ocioso;
      end
    endcase
  end

  // State-decoded debug outputs.
  always_comb begin
    w_db_estado  = r_estado;
    w_tem_jogada = 1'b0;
    if ((r_estado == c_valido) || (r_estado == c_liberando)) begin
      w_tem_jogada = 1'b1;
    end
  end

  // Synchroniser, datapath registers and registered capture outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1        <= 4'b0000;
      r_sync2        <= 4'b0000;
      r_cnt          <= c_cnt_zero;
      r_candidato    <= 4'b0000;
      r_jogada       <= 4'b0000;
      r_jogada_feita <= 1'b0;
      r_multipla     <= 1'b0;
    end else begin
      r_sync1        <= bus.chaves;
      r_sync2        <= r_sync1;
      r_cnt          <= w_cnt_prox;
      r_candidato    <= w_cand_prox;
      r_jogada_feita <= w_aceita;
      r_multipla     <= w_aceita & w_multipla;
      if (w_aceita) begin
        r_jogada <= w_cand_prox;
      end
    end
  end

  assign bus.jogada        = r_jogada;
  assign bus.jogada_feita  = r_jogada_feita;
  assign bus.multipla      = r_multipla;
  assign bus.db_tem_jogada = w_tem_jogada;
  assign bus.db_estado     = w_db_estado;

endmodule
`default_nettype wire

// File: tb/tb_captura_jogada.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_captura_jogada
//  Description : Self-checking bench for captura_jogada: directed press,
//                glitch, bounce, habilita and reset scenarios followed by
//                random switch activity, all compared cycle by cycle against
//                a run-length reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_captura_jogada;

  localparam int DEB = 4;

  logic clock = 1'b0;
  logic reset;

  always #10 clock = ~clock;

  captura_jogada_if bus ();

  captura_jogada #(
    .DEBOUNCE_CICLOS(DEB),
    .CW             (3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a delay line for the synchroniser, then run lengths of
  // identical enabled nonzero samples (to accept) and of zero samples (to
  // re-arm).
  logic [3:0] m_sync1, m_sync2;
  logic       m_armed;
  logic [3:0] m_run_val;
  int         m_run_len;
  int         m_zero_len;
  logic [3:0] m_jogada;
  logic       m_pulso;
  logic       m_mult;

  // Observation bookkeeping for directed timing checks.
  int   ciclo = 0;
  int   n_pulsos = 0;
  int   ultimo_pulso = -1;
  int   n_mult = 0;
  int   queda = -1;
  logic prev_tem = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ciclo);
    end
  endtask

  task automatic model_step(input logic rst, input logic hab, input logic [3:0] ch);
    logic [3:0] s;
    if (rst) begin
      m_sync1 = 4'b0; m_sync2 = 4'b0;
      m_armed = 1'b1; m_run_val = 4'b0; m_run_len = 0; m_zero_len = 0;
      m_jogada = 4'b0; m_pulso = 1'b0; m_mult = 1'b0;
      return;
    end
    s       = m_sync2;
    m_sync2 = m_sync1;
    m_sync1 = ch;
    m_pulso = 1'b0;
    m_mult  = 1'b0;
    if (m_armed) begin
      if (s != 4'b0 && hab) begin
        if (m_run_len > 0 && s == m_run_val) m_run_len++;
        else begin
          m_run_val = s;
          m_run_len = 1;
        end
        if (m_run_len >= DEB) begin
          m_pulso    = 1'b1;
          m_jogada   = s;
          m_mult     = ($countones(s) > 1);
          m_armed    = 1'b0;
          m_zero_len = 0;
          m_run_len  = 0;
        end
      end else begin
        m_run_len = 0;
      end
    end else begin
      if (s == 4'b0) begin
        m_zero_len++;
        if (m_zero_len >= DEB) begin
          m_armed    = 1'b1;
          m_zero_len = 0;
        end
      end else begin
        m_zero_len = 0;
      end
    end
  endtask

  function automatic logic [3:0] m_codigo();
    if (m_armed) return (m_run_len > 0) ? 4'b0001 : 4'b0000;
    return (m_zero_len > 0) ? 4'b0011 : 4'b0010;
  endfunction

  // One clock: drive inputs, advance the model on the edge, compare at negedge.
  task automatic tick(input logic rst, input logic hab, input logic [3:0] ch);
    reset        = rst;
    bus.habilita = hab;
    bus.chaves   = ch;
    @(posedge clock);
    model_step(rst, hab, ch);
    @(negedge clock);
    ciclo++;
    if (bus.jogada_feita === 1'b1) begin
      n_pulsos++;
      ultimo_pulso = ciclo;
    end
    if (bus.multipla === 1'b1) n_mult++;
    if (prev_tem === 1'b1 && bus.db_tem_jogada === 1'b0) queda = ciclo;
    prev_tem = bus.db_tem_jogada;
    check_eq("jogada",        32'(bus.jogada),        32'(m_jogada));
    check_eq("jogada_feita",  32'(bus.jogada_feita),  32'(m_pulso));
    check_eq("multipla",      32'(bus.multipla),      32'(m_mult));
    check_eq("db_tem_jogada", 32'(bus.db_tem_jogada), 32'(!m_armed));
    check_eq("db_estado",     32'(bus.db_estado),     32'(m_codigo()));
  endtask

  task automatic hold(input int n, input logic hab, input logic [3:0] ch);
    for (int i = 0; i < n; i++) tick(1'b0, hab, ch);
  endtask

  int inicio;
  int rel;

  initial begin
    reset        = 1'b1;
    bus.habilita = 1'b0;
    bus.chaves   = 4'b0;

    // Reset state.
    tick(1'b1, 1'b0, 4'b0);
    tick(1'b1, 1'b0, 4'b0);
    check_eq("reset_jogada", 32'(bus.jogada), 32'h0);
    check_eq("reset_estado", 32'(bus.db_estado), 32'h0);

    // Clean press of 0001: pulse DEB+1 edges after the change, release timing.
    n_pulsos = 0;
    inicio   = ciclo + 1;
    hold(10, 1'b1, 4'b0001);
    rel = ciclo + 1;
    hold(10, 1'b1, 4'b0000);
    check_eq("p1_pulsos", 32'(n_pulsos), 32'd1);
    check_eq("p1_latencia", 32'(ultimo_pulso - inicio), 32'(DEB + 1));
    check_eq("p1_jogada", 32'(bus.jogada), 32'h1);
    check_eq("p1_queda", 32'(queda - rel), 32'(DEB + 1));

    // Glitch shorter than the debounce window.
    n_pulsos = 0;
    hold(3, 1'b1, 4'b0100);
    hold(6, 1'b1, 4'b0000);
    check_eq("glitch_pulsos", 32'(n_pulsos), 32'd0);
    check_eq("glitch_jogada", 32'(bus.jogada), 32'h1);
    check_eq("glitch_estado", 32'(bus.db_estado), 32'h0);

    // Minimum-width press, then a different key.
    n_pulsos = 0;
    hold(DEB + 1, 1'b1, 4'b0001);
    hold(8, 1'b1, 4'b0000);
    check_eq("min_pulsos", 32'(n_pulsos), 32'd1);
    check_eq("min_jogada", 32'(bus.jogada), 32'h1);
    hold(10, 1'b1, 4'b1000);
    hold(8, 1'b1, 4'b0000);
    check_eq("p8_pulsos", 32'(n_pulsos), 32'd2);
    check_eq("p8_jogada", 32'(bus.jogada), 32'h8);

    // Multiple keys: multipla only alongside the pulse.
    n_pulsos = 0;
    n_mult   = 0;
    hold(10, 1'b1, 4'b0110);
    hold(8, 1'b1, 4'b0000);
    check_eq("mult_pulsos", 32'(n_pulsos), 32'd1);
    check_eq("mult_count", 32'(n_mult), 32'd1);
    check_eq("mult_jogada", 32'(bus.jogada), 32'h6);

    // Bounce on release.
    n_pulsos = 0;
    hold(10, 1'b1, 4'b0010);
    hold(2, 1'b1, 4'b0000);
    hold(2, 1'b1, 4'b0010);
    rel = ciclo + 1;
    hold(10, 1'b1, 4'b0000);
    check_eq("bounce_pulsos", 32'(n_pulsos), 32'd1);
    check_eq("bounce_queda", 32'(queda - rel), 32'(DEB + 1));

    // habilita low: nothing captured.
    n_pulsos = 0;
    hold(10, 1'b0, 4'b0011);
    hold(4, 1'b0, 4'b0000);
    check_eq("hab0_pulsos", 32'(n_pulsos), 32'd0);
    check_eq("hab0_jogada", 32'(bus.jogada), 32'h2);

    // Reset while holding an accepted play, then recapture the held keys.
    hold(10, 1'b1, 4'b0101);
    check_eq("pre_reset_tem", 32'(bus.db_tem_jogada), 32'd1);
    tick(1'b1, 1'b1, 4'b0101);
    check_eq("rst_jogada", 32'(bus.jogada), 32'h0);
    check_eq("rst_tem", 32'(bus.db_tem_jogada), 32'd0);
    check_eq("rst_estado", 32'(bus.db_estado), 32'h0);
    n_pulsos = 0;
    hold(10, 1'b1, 4'b0101);
    check_eq("recap_pulsos", 32'(n_pulsos), 32'd1);
    check_eq("recap_jogada", 32'(bus.jogada), 32'h5);
    hold(8, 1'b1, 4'b0000);

    // Random switch activity with occasional habilita drops and resets.
    for (int seg = 0; seg < 400; seg++) begin
      logic [3:0] ch;
      logic       hab;
      int         len;
      ch  = ($urandom_range(0, 9) < 4) ? 4'b0 : 4'($urandom_range(1, 15));
      hab = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) tick(1'b1, hab, ch);
      else hold(len, hab, ch);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
